// File: rtl/cpu_pkg.sv
// Shared types and constants for the fetch / PC path
// of the single-cycle MIPS core.
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2,
    FAULT = 2'd3
  } state_t;

  localparam logic [1:0] PC_SEQ = 2'b00;
  localparam logic [1:0] PC_BR  = 2'b01;
  localparam logic [1:0] PC_J   = 2'b10;
  localparam logic [1:0] PC_JR  = 2'b11;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection: sequential, branch,
// jump and register jump, plus jr alignment check.
module next_pc_calc
  import cpu_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] ins,
  input  logic [1:0]  PCSrc,
  input  logic [31:0] rs_data,
  output logic [31:0] next_pc,
  output logic        misalign
);

  logic [31:0] seq;
  logic [31:0] br_off;
  logic        unused_op;

  assign seq       = pc + 32'd4;
  assign br_off    = {{14{ins[15]}}, ins[15:0], 2'b00};
  assign unused_op = ^ins[31:26];

  always_comb begin
    next_pc = seq;
    case (PCSrc)
      PC_SEQ: next_pc = seq;
      PC_BR:  next_pc = seq + br_off;
      PC_J:   next_pc = {seq[31:28], ins[25:0], 2'b00};
      PC_JR:  next_pc = rs_data;
      default: next_pc = seq;
    endcase
  end

  // Only register jumps can produce an unaligned target.
  assign misalign = (PCSrc == PC_JR) && (rs_data[1:0] != 2'b00);

endmodule

// File: rtl/fetch_pc_unit.sv
// Program counter, fetch handshake and retire counter
// for the single-cycle MIPS core.
module fetch_pc_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int          ADDR_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       ins,
  output logic              ins_valid,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus4,
  input  logic [1:0]        PCSrc,
  input  logic [31:0]       rs_data,
  input  logic              stall,
  output logic              exc_misalign,
  output logic [31:0]       retired
);

  state_t      state, state_n;
  logic [31:0] next_pc;
  logic        misalign;
  logic        commit;
  logic        load;

  next_pc_calc u_npc (
    .pc       (pc),
    .ins      (ins),
    .PCSrc    (PCSrc),
    .rs_data  (rs_data),
    .next_pc  (next_pc),
    .misalign (misalign)
  );

  assign imem_req  = (state == FETCH);
  assign imem_addr = pc;
  assign ins_valid = (state == EXEC);
  assign pc_plus4  = pc + 32'd4;
  assign load      = imem_req && imem_ready;
  assign commit    = ins_valid && !stall && !misalign;

  always_comb begin
    state_n = state;
    case (state)
      IDLE:  state_n = FETCH;
      FETCH: if (imem_ready) state_n = EXEC;
      EXEC:  if (!stall) state_n = misalign ? FAULT : FETCH;
      FAULT: state_n = FAULT;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      pc           <= RESET_PC;
      ins          <= '0;
      retired      <= '0;
      exc_misalign <= 1'b0;
    end else begin
      state <= state_n;
      if (load)
        ins <= imem_rdata;
      if (commit) begin
        pc      <= next_pc;
        retired <= retired + 32'd1;
      end
      if (ins_valid && !stall && misalign)
        exc_misalign <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Randomized self-checking bench for fetch_pc_unit against
// a transaction-level model of the PC and retire count.
module tb_fetch_pc_unit;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] ins;
  logic        ins_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [1:0]  PCSrc;
  logic [31:0] rs_data;
  logic        stall;
  logic        exc_misalign;
  logic [31:0] retired;

  int passed = 0;
  int total  = 0;

  logic [31:0] m_pc;
  logic [31:0] m_ret;
  logic [31:0] m_ins;

  fetch_pc_unit dut (
    .clk          (clk),
    .rst          (rst),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ready   (imem_ready),
    .imem_rdata   (imem_rdata),
    .ins          (ins),
    .ins_valid    (ins_valid),
    .pc           (pc),
    .pc_plus4     (pc_plus4),
    .PCSrc        (PCSrc),
    .rs_data      (rs_data),
    .stall        (stall),
    .exc_misalign (exc_misalign),
    .retired      (retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Target address from the ISA rules, as plain arithmetic.
  function automatic logic [31:0] model_target(
    input logic [31:0] cur, input logic [31:0] word,
    input logic [1:0] src, input logic [31:0] rs);
    int          off;
    logic [31:0] lo16;
    logic [31:0] r;
    lo16 = word & 32'h0000_FFFF;
    off  = (lo16 >= 32'h8000) ? int'(lo16) - 65536 : int'(lo16);
    case (src)
      2'd0: r = cur + 32'd4;
      2'd1: r = cur + 32'd4 + 32'(off * 4);
      2'd2: r = ((cur + 32'd4) & 32'hF000_0000)
              | ((word & 32'h03FF_FFFF) * 32'd4);
      default: r = rs;
    endcase
    return r;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    imem_ready = 1'b0;
    stall = 1'b0;
    #1;
    m_pc = 32'h0000_3000;
    m_ret = 0;
    m_ins = 0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One instruction: fetch with wait states, execute with stalls.
  task automatic fetch_exec(input int wait_n, input logic [31:0] word,
                            input logic [1:0] src, input logic [31:0] rs,
                            input int stall_n);
    logic [31:0] tgt;
    for (int i = 0; i < 4 && imem_req !== 1'b1; i++) @(negedge clk);
    total++;
    if (imem_req !== 1'b1 || imem_addr !== m_pc)
      $display("FAIL fetch_addr req=%b addr=%h exp %h", imem_req, imem_addr, m_pc);
    else passed++;
    for (int i = 0; i < wait_n; i++) begin
      imem_ready = 1'b0;
      imem_rdata = $urandom;
      @(negedge clk);
      total++;
      if (imem_req !== 1'b1 || imem_addr !== m_pc || ins !== m_ins)
        $display("FAIL fetch_wait req=%b addr=%h ins=%h exp addr %h ins %h",
                 imem_req, imem_addr, ins, m_pc, m_ins);
      else passed++;
    end
    imem_ready = 1'b1;
    imem_rdata = word;
    @(negedge clk);
    imem_ready = 1'b0;
    imem_rdata = $urandom;
    m_ins = word;
    total++;
    if (ins_valid !== 1'b1 || ins !== word || pc !== m_pc
        || pc_plus4 !== m_pc + 32'd4 || imem_req !== 1'b0)
      $display("FAIL exec_entry v=%b ins=%h pc=%h p4=%h req=%b exp ins %h pc %h",
               ins_valid, ins, pc, pc_plus4, imem_req, word, m_pc);
    else passed++;
    for (int i = 0; i < stall_n; i++) begin
      stall = 1'b1;
      PCSrc = 2'($urandom);
      rs_data = $urandom;
      @(negedge clk);
      total++;
      if (ins_valid !== 1'b1 || pc !== m_pc || retired !== m_ret)
        $display("FAIL stall_hold v=%b pc=%h ret=%0d exp pc %h ret %0d",
                 ins_valid, pc, retired, m_pc, m_ret);
      else passed++;
    end
    stall = 1'b0;
    PCSrc = src;
    rs_data = rs;
    tgt = model_target(m_pc, word, src, rs);
    @(negedge clk);
    PCSrc = 2'($urandom);
    rs_data = $urandom;
    if (src == 2'd3 && (rs % 4) != 0) begin
      total++;
      if (exc_misalign !== 1'b1 || ins_valid !== 1'b0
          || imem_req !== 1'b0 || pc !== m_pc || retired !== m_ret)
        $display("FAIL fault_entry exc=%b v=%b req=%b pc=%h ret=%0d exp pc %h ret %0d",
                 exc_misalign, ins_valid, imem_req, pc, retired, m_pc, m_ret);
      else passed++;
    end else begin
      m_pc = tgt;
      m_ret = m_ret + 1;
      total++;
      if (pc !== m_pc || retired !== m_ret || imem_req !== 1'b1
          || imem_addr !== m_pc || exc_misalign !== 1'b0)
        $display("FAIL commit pc=%h ret=%0d req=%b exc=%b exp pc %h ret %0d",
                 pc, retired, imem_req, exc_misalign, m_pc, m_ret);
      else passed++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    total++;
    if (pc !== 32'h3000 || ins !== 0 || retired !== 0 || imem_req !== 0
        || ins_valid !== 0 || exc_misalign !== 0)
      $display("FAIL reset pc=%h ins=%h ret=%0d req=%b v=%b exc=%b exp pc 3000",
               pc, ins, retired, imem_req, ins_valid, exc_misalign);
    else passed++;
    do_reset();
  endtask

  task automatic test_sequential();
    do_reset();
    for (int i = 0; i < 3; i++) fetch_exec(0, $urandom, 2'd0, 0, 0);
    total++;
    if (retired !== 3 || pc !== 32'h300C)
      $display("FAIL seq_three ret=%0d pc=%h exp 3 300c", retired, pc);
    else passed++;
  endtask

  task automatic test_ready_wait();
    do_reset();
    fetch_exec(4, 32'hDEAD_BEEF, 2'd0, 0, 0);
  endtask

  task automatic test_branch_jump();
    do_reset();
    fetch_exec(0, $urandom, 2'd3, 32'h3010, 0);
    fetch_exec(1, 32'h1000_FFFE, 2'd1, 0, 0);
    total++;
    if (pc !== 32'h300C) $display("FAIL branch_back pc=%h exp 300c", pc);
    else passed++;
    fetch_exec(0, 32'h0800_0C10, 2'd2, 0, 0);
    total++;
    if (pc !== 32'h3040) $display("FAIL jump pc=%h exp 3040", pc);
    else passed++;
  endtask

  task automatic test_stall();
    do_reset();
    fetch_exec(0, 32'h0800_1000, 2'd2, 0, 3);
    total++;
    if (pc !== 32'h4000 || retired !== 1)
      $display("FAIL stall_once pc=%h ret=%0d exp 4000 1", pc, retired);
    else passed++;
  endtask

  task automatic test_wrap();
    do_reset();
    fetch_exec(0, $urandom, 2'd3, 32'hFFFF_FFFC, 0);
    fetch_exec(0, $urandom, 2'd0, 0, 0);
    total++;
    if (imem_addr !== 32'h0) $display("FAIL wrap addr=%h exp 0", imem_addr);
    else passed++;
    fetch_exec(0, 32'h1000_FFFD, 2'd1, 0, 0);
  endtask

  task automatic test_random();
    logic [1:0]  src;
    logic [31:0] rs;
    do_reset();
    for (int n = 0; n < 40; n++) begin
      src = 2'($urandom);
      rs = $urandom & 32'hFFFF_FFFC;
      fetch_exec(int'($urandom_range(0, 3)), $urandom, src, rs,
                 int'($urandom_range(0, 2)));
    end
  endtask

  task automatic test_fault();
    int bad;
    do_reset();
    fetch_exec(0, $urandom, 2'd0, 0, 0);
    fetch_exec(0, $urandom, 2'd3, 32'h3102, 1);
    bad = 0;
    imem_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (imem_req !== 0 || pc !== 32'h3004 || exc_misalign !== 1
          || ins_valid !== 0) bad++;
    end
    total++;
    if (bad != 0) $display("FAIL fault_sticky bad_cycles=%0d exp 0", bad);
    else passed++;
    do_reset();
    total++;
    if (pc !== 32'h3000 || exc_misalign !== 0 || retired !== 0)
      $display("FAIL fault_clear pc=%h exc=%b ret=%0d exp 3000 0 0",
               pc, exc_misalign, retired);
    else passed++;
  endtask

  task automatic test_rst_midfetch();
    do_reset();
    fetch_exec(0, $urandom, 2'd0, 0, 0);
    total++;
    if (imem_req !== 1'b1) $display("FAIL midfetch_pre req=%b exp 1", imem_req);
    else passed++;
    #2;
    rst = 1'b1;
    #1;
    total++;
    if (imem_req !== 1'b0 || pc !== 32'h3000)
      $display("FAIL midfetch_drop req=%b pc=%h exp 0 3000", imem_req, pc);
    else passed++;
    imem_ready = 1'b1;
    imem_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    total++;
    if (ins !== 0 || ins_valid !== 0 || imem_req !== 0)
      $display("FAIL midfetch_late ins=%h v=%b req=%b exp 0 0 0",
               ins, ins_valid, imem_req);
    else passed++;
    imem_ready = 1'b0;
    rst = 1'b0;
    m_pc = 32'h3000;
    m_ret = 0;
    m_ins = 0;
    fetch_exec(0, $urandom, 2'd0, 0, 0);
  endtask

  initial begin
    rst = 1'b1;
    imem_ready = 1'b0;
    imem_rdata = '0;
    PCSrc = 2'd0;
    rs_data = '0;
    stall = 1'b0;
    test_reset();
    test_sequential();
    test_ready_wait();
    test_branch_jump();
    test_stall();
    test_wrap();
    test_random();
    test_fault();
    test_rst_midfetch();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
